// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: brings up an audio codec over I2C by writing a table of
// register/value pairs, then enables the I2S sample path (audio_en) and serves
// runtime volume writes on the same bus.
// Optional feature macro: CODEC_RETRY_EN (retry a NACKed write up to 3 times).
module codec_cfg_sequencer #(
  parameter int         CLK_DIV  = 40,
  parameter logic [6:0] DEV_ADDR = 7'h4A,
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] VOL_REG  = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  tbl_idx,
  input  logic [15:0] tbl_data,
  input  logic        vol_req,
  input  logic [7:0]  vol_val,
  output logic        vol_ack,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        nack_err,
  output logic        audio_en
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_VLOAD, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, state_next;
  logic [CW-1:0] div_cnt;
  logic          run, tick, gap_end, more_regs, retry_ok;
  logic [1:0]    ph;        // phase (quarter-bit tick) within the current state
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   sh;        // {address byte, register byte, value byte}, MSB on the wire
  logic          nack_q;
  logic          is_vol;
  logic [7:0]    vol_q;

  // The divider only runs while a bus phase is in progress, so every
  // transaction starts phase-aligned.
  assign run       = !(state inside {S_IDLE, S_LOAD, S_VLOAD, S_DONE, S_ERR});
  assign tick      = run && (div_cnt == CW'(CLK_DIV - 1));
  assign gap_end   = (state == S_GAP) && tick && (ph == 2'd3);
  assign more_regs = (int'(tbl_idx) + 1) < NUM_REGS;

`ifdef CODEC_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry_ok = (retry_cnt != 2'd3);

  // Retry counter: counts NACKed attempts of the current entry, cleared on ACK.
  always_ff @(posedge clk) begin
    if (!reset)       retry_cnt <= 2'd0;
    else if (gap_end) retry_cnt <= nack_q ? retry_cnt + 2'd1 : 2'd0;
  end
`else
  assign retry_ok = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: bus phases advance only on tick.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:          if (start) state_next = S_LOAD;
      S_LOAD, S_VLOAD: state_next = S_START;
      S_START:         if (tick && ph == 2'd2) state_next = S_BIT;
      S_BIT:           if (tick && ph == 2'd3 && bit_cnt == 3'd7) state_next = S_ACK;
      S_ACK:           if (tick && ph == 2'd3)
                         state_next = (nack_q || byte_cnt == 2'd2) ? S_STOP : S_BIT;
      S_STOP:          if (tick && ph == 2'd2) state_next = S_GAP;
      S_GAP: begin
        if (gap_end) begin
          if (nack_q)                  state_next = retry_ok ? (is_vol ? S_VLOAD : S_LOAD) : S_ERR;
          else if (is_vol || !more_regs) state_next = S_DONE;
          else                         state_next = S_LOAD;
        end
      end
      S_DONE:          if (vol_req) state_next = S_VLOAD;
      S_ERR:           state_next = S_ERR;
      default:         state_next = S_IDLE;
    endcase
  end

  // Datapath: divider, phase/bit/byte counters, shift register and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt  <= '0;
      ph       <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      sh       <= 24'd0;
      nack_q   <= 1'b0;
      is_vol   <= 1'b0;
      vol_q    <= 8'd0;
      tbl_idx  <= 4'd0;
      done     <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      div_cnt <= (!run || tick) ? '0 : div_cnt + CW'(1);
      ph      <= (state_next != state) ? 2'd0 : (tick ? ph + 2'd1 : ph);

      if (state == S_LOAD || state == S_VLOAD) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
        nack_q   <= 1'b0;
      end
      if (state == S_DONE && vol_req) begin
        is_vol <= 1'b1;
        vol_q  <= vol_val;
      end
      // The ROM only presents the entry for a new tbl_idx one clk after LOAD,
      // so the frame is captured at the end of the START idle phase instead.
      if (state == S_START && tick && ph == 2'd0)
        sh <= {DEV_ADDR, 1'b0, (is_vol ? {VOL_REG, vol_q} : tbl_data)};
      if (state == S_BIT && tick && ph == 2'd3) begin
        sh      <= sh << 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == S_ACK && tick && ph == 2'd2) nack_q <= sda_i;
      if (state == S_ACK && tick && ph == 2'd3) byte_cnt <= byte_cnt + 2'd1;
      if (gap_end && !nack_q && !is_vol) tbl_idx <= tbl_idx + 4'd1;

      if (state_next == S_ERR) begin
        done     <= 1'b0;
        nack_err <= 1'b1;
      end else if (state_next == S_DONE) begin
        done <= 1'b1;
      end
    end
  end

  // Bus pin drive and status outputs decoded from state and phase.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        sda_oe = (ph != 2'd0);
        scl_oe = (ph == 2'd2);
      end
      S_BIT: begin
        sda_oe = ~sh[23];
        scl_oe = (ph == 2'd0) || (ph == 2'd3);
      end
      S_ACK:   scl_oe = (ph == 2'd0) || (ph == 2'd3);
      S_STOP: begin
        sda_oe = (ph != 2'd2);
        scl_oe = (ph == 2'd0);
      end
      default: ;
    endcase
    busy     = !(state inside {S_IDLE, S_DONE, S_ERR});
    vol_ack  = gap_end && !nack_q && is_vol;
    audio_en = done && !nack_err;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

- Sequences the audio path's bring-up: after `start`, writes a table of codec register/value pairs over an I2C master, then asserts `audio_en` to gate the I2S serializer's sample `load`.
- After configuration, serves runtime volume-write requests over the same bus.
- Sits between the 16 MHz system clock domain top level and the external codec control pins.

## Interface
Parameters:
- CLK_DIV, 40: system clocks per I2C quarter-bit tick (16 MHz / (4·40) = 100 kHz SCL).
- DEV_ADDR, 7'h4A: codec 7-bit I2C address; write byte is {DEV_ADDR,1'b0}.
- NUM_REGS, 8: table entries written at bring-up (1..16).
- VOL_REG, 8'h20: codec register written by volume requests.

Ports:
- clk input 1: system clock, 16 MHz.
- reset input 1: synchronous, active-low reset.
- start input 1: one-cycle pulse; begins configuration when idle.
- tbl_idx output 4: table address; reset 0.
- tbl_data input 16: {reg_addr[15:8], value[7:0]}; valid one clk after tbl_idx changes (synchronous ROM).
- vol_req input 1: level request for a volume write; honoured only in DONE.
- vol_val input 8: volume value, sampled when vol_req is accepted.
- vol_ack output 1: one-cycle pulse when the volume write completes; reset 0.
- scl_oe output 1: 1 pulls SCL low, 0 releases it; reset 0.
- sda_oe output 1: 1 pulls SDA low, 0 releases it; reset 0.
- sda_i input 1: sampled SDA line.
- busy output 1: a transaction is in progress; reset 0.
- done output 1: table fully written; reset 0.
- nack_err output 1: sticky; unrecoverable NACK; reset 0.
- audio_en output 1: equals done & ~nack_err; drives I2S load gating; reset 0.

## Operation
- Tick generator: counter 0..CLK_DIV-1; `tick` is asserted when the count wraps. All bus phases advance only on tick.
- States:
  - IDLE: start → LOAD.
  - LOAD: one clk; latch tbl_data into shift regs; byte0 = {DEV_ADDR,0}, byte1 = reg_addr, byte2 = value; → START.
  - START: 3 ticks.
    - tick0: SDA and SCL released.
    - tick1: SDA low.
    - tick2: SCL low.
    - → BIT.
  - BIT: per bit, 4 ticks.
    - t0: SCL low, drive MSB (sda_oe = ~bit).
    - t1: SCL released.
    - t2: SCL high, hold.
    - t3: SCL low.
    - After 8 bits, → ACK.
  - ACK: same 4 ticks with SDA released; sda_i is sampled on t2. A value of 0 (ACK) advances to the next byte, or to STOP after byte2. A value of 1 (NACK) → STOP with the nack flag set.
  - STOP: 3 ticks.
    - tick0: SDA low, SCL low.
    - tick1: SCL released.
    - tick2: SDA released.
    - → GAP.
  - GAP: 4 ticks of bus idle.
    - If nack: retry or → ERR.
    - Else if the entry was from the table: tbl_idx++, and → LOAD if tbl_idx < NUM_REGS, else → DONE.
    - If it was a volume write: pulse vol_ack, → DONE.
  - DONE: done=1. vol_req=1 → VLOAD (byte1 = VOL_REG, byte2 = vol_val) → START. A start pulse here is ignored.
  - ERR: nack_err=1, bus released; only reset exits.
- busy = 1 in every state except IDLE, DONE and ERR.
- Bits are shifted MSB first. The tick counter is held at 0 in IDLE, DONE and ERR, so every transaction starts phase-aligned.
- Reset at any time: all outputs go to their reset values in the same clk and the bus is released immediately. A partially sent transaction is abandoned without a STOP.

## Timing
- One bit = 4·CLK_DIV clk = 160 clk at default.
- Full write transaction: START 3 + 27 bits·4 + STOP 3 = 114 ticks; with GAP, 118 ticks = 4720 clk.
- LOAD adds 1 clk.
- Bring-up with NUM_REGS=8: 8·4721 clk, counted from the clk after start to the rising edge of done.
- tbl_idx is stable from LOAD through GAP.
- vol_req is sampled in DONE each clk. vol_ack pulses at GAP exit, and done stays 1 throughout the volume write.
- Simultaneous start and vol_req in IDLE: start wins and vol_req is ignored.
- vol_req held after vol_ack causes a new write; the requester must drop vol_req on vol_ack.

## Configuration
- CODEC_RETRY_EN defined:
  - A NACK repeats the same entry, via LOAD, up to 3 retries (4 attempts total).
  - The retry counter is cleared on each ACKed entry.
  - A 4th NACK → ERR.
- Undefined: the first NACK → ERR.
- Both modes: nack_err is set only on entering ERR.

## Test plan
- Reset, then start with an ACKing codec model and table entry i = {8'h0i, 8'hAi}:
  - Observe 8 frames on the bus: 0x94, 0x0i, 0xAi.
  - done rises 37768 clk after start; audio_en=1.
- Release reset low mid-byte2 of entry 3: scl_oe=0, sda_oe=0, busy=0 and tbl_idx=0 on the next clk; a new start restarts from entry 0.
- Codec NACKs the address byte of entry 2 once, with the retry macro on: entry 2 is re-sent; done=1; nack_err=0.
- Codec always NACKs entry 5:
  - With the macro: 4 attempts, then nack_err=1, audio_en=0, done=0.
  - Without the macro: 1 attempt, then the same result.
- In DONE, pulse vol_req with vol_val=8'h3C: bus carries 0x94, 0x20, 0x3C; vol_ack is a 1-clk pulse 4720 clk later; done stays 1.
- Start in IDLE at the same clk as vol_req=1: configuration begins (byte1 = table entry 0 reg), and no volume write occurs.
